count_stepper: RTL

// - Command-side initiator for the load/inc/dec up/down counter: drives its load, inc, dec and din.
// - Observes its count, saturated and zeroed, and walks it to a requested target value.
// - A request is accepted over a valid/ready handshake; completion is a one-cycle done pulse.
// - Sits between control logic and the counter instance, so control never sequences the counter directly.

---
 rtl/count_stepper.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/count_stepper.sv
// count_stepper
//   Command-side initiator for a load/inc/dec up/down counter. It accepts a
//   target value over a valid/ready handshake. It then walks the counter to
//   that value, either with inc/dec steps (req_mode=0) or with one direct
//   load (req_mode=1). It reports completion with a one-cycle done pulse,
//   qualified by err.
//
//   Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both 1. req_ready is 1 only in IDLE. While busy, req_valid
//   is ignored and the request is not queued.
//
// Parameters
//   N          counter data width (must match the counter instance)
//   MAX_STEPS  inc/dec cycles allowed per request before abort with err
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   req_valid   request present
//   req_ready   stepper idle; request accepted when req_valid & req_ready
//   req_target  target count value
//   req_mode    0 = step with inc/dec, 1 = direct load of req_target
//   load/inc/dec/din  commands to the counter (din valid while load=1)
//   count/saturated/zeroed  status from the counter
//   done        one-cycle completion pulse
//   err         qualifies done: 1 = aborted/failed
//   state_dbg   current FSM state encoding (debug observation)
//
// Optional feature
//   COUNT_STEPPER_SVA_EN  when defined, concurrent assertions are compiled in.
module count_stepper #(
  parameter int N         = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_target,
  input  logic         req_mode,
  output logic         load,
  output logic         inc,
  output logic         dec,
  output logic [N-1:0] din,
  input  logic [N-1:0] count,
  input  logic         saturated,
  input  logic         zeroed,
  output logic         done,
  output logic         err,
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [N:0] STEP_LIMIT = (N+1)'(MAX_STEPS);

  state_t       state, state_nx;
  logic [N-1:0] target_q;
  logic [N:0]   steps_q;
  logic         err_q, err_nx;

  logic accept;
  logic want_inc, want_dec, at_target;
  logic limit_hit, guard_hit, step_go;

  assign accept    = req_valid & req_ready;
  assign want_inc  = (count < target_q);
  assign want_dec  = (count > target_q);
  assign at_target = (count == target_q);
  assign limit_hit = (steps_q == STEP_LIMIT);
  // The counter claims it cannot move in the wanted direction, so the
  // counter and this stepper disagree about its state.
  assign guard_hit = (want_inc & saturated) | (want_dec & zeroed);
  // A step command is issued only when no STEP exit condition applies.
  assign step_go   = (state == S_STEP) & ~at_target & ~limit_hit & ~guard_hit;

  // State register and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      target_q <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      if (accept) begin
        target_q <= req_target;
        steps_q  <= '0;
      end else if (step_go) begin
        steps_q  <= steps_q + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = req_mode ? S_LOAD : S_STEP;
          err_nx   = 1'b0;
        end
      end
      S_LOAD:  state_nx = S_CHECK;
      // The load took effect on the edge entering CHECK, so count is current.
      S_CHECK: begin
        state_nx = S_DONE;
        err_nx   = (count != target_q);
      end
      S_STEP: begin
        if (at_target) begin
          state_nx = S_DONE;
          err_nx   = 1'b0;
        end else if (limit_hit || guard_hit) begin
          state_nx = S_DONE;
          err_nx   = 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state == S_IDLE);
    load      = (state == S_LOAD);
    din       = (state == S_LOAD) ? target_q : '0;
    inc       = step_go & want_inc;
    dec       = step_go & want_dec;
    done      = (state == S_DONE);
    err       = (state == S_DONE) & err_q;
    state_dbg = state;
  end

`ifdef COUNT_STEPPER_SVA_EN
  a_onehot_cmd: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({load, inc, dec}));
  a_done_pulse: assert property (@(posedge clk) disable iff (!reset)
    done |=> !done);
  a_err_with_done: assert property (@(posedge clk) disable iff (!reset)
    err |-> done);
  a_ready_busy: assert property (@(posedge clk) disable iff (!reset)
    (state != S_IDLE) |-> !req_ready);
  a_no_inc_sat: assert property (@(posedge clk) disable iff (!reset)
    saturated |-> !inc);
  a_no_dec_zero: assert property (@(posedge clk) disable iff (!reset)
    zeroed |-> !dec);
`else
`endif

endmodule
